// File: rtl/bsg_manycore_wh_side_concentrator.sv
// bsg_manycore_wh_side_concentrator
//
// Edge concentrator between the num_in_p vcache wormhole lanes of one pod row
// (one side, one N/S half) and a single wormhole link toward memory.
//
//   forward : num_in_p lanes -> 2-entry FIFO per lane -> round-robin per-packet
//             arbiter -> fwd_v_o / fwd_data_o
//   reverse : rev_v_i / rev_data_i -> 2-entry FIFO -> demux on header cid
//             -> rev_v_o[cid] (rev_data_o is broadcast to every lane)
//
// Ports
//   clk_i, reset_i                      clock, synchronous active-high reset
//   fwd_v_i/fwd_data_i/fwd_ready_and_o  array-side lanes in (valid/ready)
//   fwd_v_o/fwd_data_o/fwd_ready_and_i  concentrated link out
//   rev_v_i/rev_data_i/rev_ready_and_o  returning link in
//   rev_v_o/rev_data_o/rev_ready_and_i  per-lane returning flits out
//
// Header layout, LSB first: cord | len | cid. A packet is a header plus len
// body flits. Ready outputs are "FIFO not full" and are forced low, like all
// valid outputs, while reset_i is high.

// Two-entry elastic buffer. ready_and_o comes only from the occupancy register
// (and reset), so it never depends on the downstream ready.
module bsg_manycore_wh_side_concentrator_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_r [2];
  logic               wptr_r;
  logic               rptr_r;
  logic [1:0]         count_r;
  logic               enq;
  logic               deq;

  assign ready_and_o = ~reset_i & (count_r != 2'd2);
  assign v_o         = (count_r != 2'd0);
  assign data_o      = mem_r[rptr_r];
  assign enq         = v_i & ready_and_o;
  assign deq         = yumi_i & v_o;

  // Pointers and occupancy; simultaneous enqueue and dequeue keep the count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) wptr_r <= ~wptr_r;
      if (deq) rptr_r <= ~rptr_r;
      count_r <= count_r + 2'(enq) - 2'(deq);
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

module bsg_manycore_wh_side_concentrator #(
  parameter int num_in_p        = 2,
  parameter int wh_flit_width_p = 16,
  parameter int wh_cord_width_p = 4,
  parameter int wh_len_width_p  = 3,
  parameter int wh_cid_width_p  = 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,

  input  logic [num_in_p-1:0]                      fwd_v_i,
  input  logic [num_in_p-1:0][wh_flit_width_p-1:0] fwd_data_i,
  output logic [num_in_p-1:0]                      fwd_ready_and_o,

  output logic                                     fwd_v_o,
  output logic [wh_flit_width_p-1:0]               fwd_data_o,
  input  logic                                     fwd_ready_and_i,

  input  logic                                     rev_v_i,
  input  logic [wh_flit_width_p-1:0]               rev_data_i,
  output logic                                     rev_ready_and_o,

  output logic [num_in_p-1:0]                      rev_v_o,
  output logic [num_in_p-1:0][wh_flit_width_p-1:0] rev_data_o,
  input  logic [num_in_p-1:0]                      rev_ready_and_i
);

  localparam int lg_lp      = $clog2(num_in_p);
  localparam int len_lsb_lp = wh_cord_width_p;
  localparam int cid_lsb_lp = wh_cord_width_p + wh_len_width_p;

  typedef enum logic {
    e_idle,
    e_locked
  } state_e;

  // ---------------------------------------------------------------- forward
  logic [num_in_p-1:0]        lane_v;
  logic [num_in_p-1:0]        lane_yumi;
  logic [wh_flit_width_p-1:0] lane_data [num_in_p];

  for (genvar i = 0; i < num_in_p; i++) begin : g_lane
    bsg_manycore_wh_side_concentrator_fifo #(
      .width_p(wh_flit_width_p)
    ) lane_fifo (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .v_i        (fwd_v_i[i]),
      .data_i     (fwd_data_i[i]),
      .ready_and_o(fwd_ready_and_o[i]),
      .v_o        (lane_v[i]),
      .data_o     (lane_data[i]),
      .yumi_i     (lane_yumi[i])
    );
  end

  state_e                    fwd_state_r, fwd_state_n;
  logic [lg_lp-1:0]          rr_r, rr_n;
  logic [lg_lp-1:0]          fwd_lane_r, fwd_lane_n;
  logic [wh_len_width_p-1:0] fwd_cnt_r, fwd_cnt_n;
  logic [lg_lp-1:0]          idle_sel;
  logic                      idle_found;
  logic [lg_lp-1:0]          fwd_cur;
  logic                      fwd_xfer;
  logic [wh_len_width_p-1:0] fwd_hdr_len;

  // Round-robin search: first non-empty lane at or after rr. The index add
  // wraps naturally because num_in_p is a power of two.
  always_comb begin
    idle_sel   = rr_r;
    idle_found = 1'b0;
    for (int k = 0; k < num_in_p; k++) begin
      if (!idle_found && lane_v[rr_r + lg_lp'(k)]) begin
        idle_sel   = rr_r + lg_lp'(k);
        idle_found = 1'b1;
      end
    end
  end

  // Arbiter: present the search winner in IDLE, the locked lane otherwise.
  // A len=0 header releases immediately; otherwise the lock lasts len bodies.
  always_comb begin
    fwd_state_n = fwd_state_r;
    rr_n        = rr_r;
    fwd_lane_n  = fwd_lane_r;
    fwd_cnt_n   = fwd_cnt_r;
    fwd_cur     = (fwd_state_r == e_locked) ? fwd_lane_r : idle_sel;
    fwd_v_o     = ~reset_i & lane_v[fwd_cur];
    fwd_data_o  = lane_data[fwd_cur];
    fwd_xfer    = fwd_v_o & fwd_ready_and_i;
    lane_yumi   = '0;
    lane_yumi[fwd_cur] = fwd_xfer;
    fwd_hdr_len = fwd_data_o[len_lsb_lp +: wh_len_width_p];
    if (fwd_xfer) begin
      if (fwd_state_r == e_idle) begin
        if (fwd_hdr_len == '0) begin
          rr_n = fwd_cur + lg_lp'(1);
        end else begin
          fwd_cnt_n   = fwd_hdr_len;
          fwd_lane_n  = fwd_cur;
          fwd_state_n = e_locked;
        end
      end else begin
        fwd_cnt_n = fwd_cnt_r - wh_len_width_p'(1);
        if (fwd_cnt_r == wh_len_width_p'(1)) begin
          fwd_state_n = e_idle;
          rr_n        = fwd_lane_r + lg_lp'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- reverse
  logic                       rev_head_v;
  logic [wh_flit_width_p-1:0] rev_head_data;
  logic                       rev_yumi;

  bsg_manycore_wh_side_concentrator_fifo #(
    .width_p(wh_flit_width_p)
  ) rev_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (rev_v_i),
    .data_i     (rev_data_i),
    .ready_and_o(rev_ready_and_o),
    .v_o        (rev_head_v),
    .data_o     (rev_head_data),
    .yumi_i     (rev_yumi)
  );

  state_e                    rev_state_r, rev_state_n;
  logic [lg_lp-1:0]          rev_lane_r, rev_lane_n;
  logic [wh_len_width_p-1:0] rev_cnt_r, rev_cnt_n;
  logic [lg_lp-1:0]          rev_cur;
  logic [wh_cid_width_p-1:0] rev_hdr_cid;
  logic [wh_len_width_p-1:0] rev_hdr_len;
  logic                      rev_xfer;

  assign rev_hdr_cid = rev_head_data[cid_lsb_lp +: wh_cid_width_p];
  assign rev_hdr_len = rev_head_data[len_lsb_lp +: wh_len_width_p];
  assign rev_data_o  = {num_in_p{rev_head_data}};

  // Demux: only the target lane sees valid; the target comes from the header
  // cid in IDLE and is held for the body flits while LOCKED.
  always_comb begin
    rev_state_n = rev_state_r;
    rev_lane_n  = rev_lane_r;
    rev_cnt_n   = rev_cnt_r;
    rev_cur     = (rev_state_r == e_locked) ? rev_lane_r : rev_hdr_cid[lg_lp-1:0];
    rev_v_o     = '0;
    rev_v_o[rev_cur] = ~reset_i & rev_head_v;
    rev_xfer    = rev_v_o[rev_cur] & rev_ready_and_i[rev_cur];
    rev_yumi    = rev_xfer;
    if (rev_xfer) begin
      if (rev_state_r == e_idle) begin
        if (rev_hdr_len != '0) begin
          rev_cnt_n   = rev_hdr_len;
          rev_lane_n  = rev_cur;
          rev_state_n = e_locked;
        end
      end else begin
        rev_cnt_n = rev_cnt_r - wh_len_width_p'(1);
        if (rev_cnt_r == wh_len_width_p'(1)) rev_state_n = e_idle;
      end
    end
  end

  // State registers for both directions; reset drops any partial packet.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fwd_state_r <= e_idle;
      rr_r        <= '0;
      fwd_lane_r  <= '0;
      fwd_cnt_r   <= '0;
      rev_state_r <= e_idle;
      rev_lane_r  <= '0;
      rev_cnt_r   <= '0;
    end else begin
      fwd_state_r <= fwd_state_n;
      rr_r        <= rr_n;
      fwd_lane_r  <= fwd_lane_n;
      fwd_cnt_r   <= fwd_cnt_n;
      rev_state_r <= rev_state_n;
      rev_lane_r  <= rev_lane_n;
      rev_cnt_r   <= rev_cnt_n;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_wh_side_concentrator.sv
// Testbench for bsg_manycore_wh_side_concentrator with four lanes.
// Flit layout: cord[3:0] (forward headers carry the source lane in cord[1:0]),
// len[6:4], cid[8:7], sequence tag[15:9].
module tb_bsg_manycore_wh_side_concentrator;

  localparam int N = 4;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                reset_i;
  logic [N-1:0]        fwd_v_i;
  logic [N-1:0][W-1:0] fwd_data_i;
  logic [N-1:0]        fwd_ready_and_o;
  logic                fwd_v_o;
  logic [W-1:0]        fwd_data_o;
  logic                fwd_ready_and_i;
  logic                rev_v_i;
  logic [W-1:0]        rev_data_i;
  logic                rev_ready_and_o;
  logic [N-1:0]        rev_v_o;
  logic [N-1:0][W-1:0] rev_data_o;
  logic [N-1:0]        rev_ready_and_i;

  always #5 clk = ~clk;

  bsg_manycore_wh_side_concentrator #(
    .num_in_p       (N),
    .wh_flit_width_p(W),
    .wh_cord_width_p(4),
    .wh_len_width_p (3),
    .wh_cid_width_p (2)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .fwd_v_i        (fwd_v_i),
    .fwd_data_i     (fwd_data_i),
    .fwd_ready_and_o(fwd_ready_and_o),
    .fwd_v_o        (fwd_v_o),
    .fwd_data_o     (fwd_data_o),
    .fwd_ready_and_i(fwd_ready_and_i),
    .rev_v_i        (rev_v_i),
    .rev_data_i     (rev_data_i),
    .rev_ready_and_o(rev_ready_and_o),
    .rev_v_o        (rev_v_o),
    .rev_data_o     (rev_data_o),
    .rev_ready_and_i(rev_ready_and_i)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int seq      = 0;

  // Stimulus sources and the packet-level reference model.
  logic [W-1:0] src_q   [N][$];
  logic [W-1:0] exp_fwd [N][$];
  logic [W-1:0] rsrc_q  [$];
  logic [W-1:0] exp_rev [N][$];
  int           cur_lane  = -1;
  int           remaining = 0;

  logic [W-1:0] fwd_log     [$];
  int           fwd_log_cyc [$];
  int           rev_log_lane[$];

  logic         rst_drv;
  logic         fwd_rdy_drv;
  logic [N-1:0] rev_rdy_drv;
  logic         hold_check_en = 1'b0;
  logic         prev_stall    = 1'b0;
  logic [W-1:0] prev_data     = '0;
  logic [N-1:0] prev_rev_stall = '0;
  logic [W-1:0] prev_rev_data  = '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_hdr(input int cord, input int len, input int cid, input int tag);
    logic [W-1:0] f;
    f        = '0;
    f[3:0]   = 4'(cord);
    f[6:4]   = 3'(len);
    f[8:7]   = 2'(cid);
    f[15:9]  = 7'(tag);
    return f;
  endfunction

  task automatic add_fwd_pkt(input int lane, input int len);
    logic [W-1:0] f;
    f = mk_hdr(lane + 4 * $urandom_range(0, 3), len, $urandom_range(0, 3), seq);
    seq++;
    src_q[lane].push_back(f);
    exp_fwd[lane].push_back(f);
    for (int b = 0; b < len; b++) begin
      f = W'($urandom);
      src_q[lane].push_back(f);
      exp_fwd[lane].push_back(f);
    end
  endtask

  task automatic add_rev_pkt(input int cid, input int len);
    logic [W-1:0] f;
    f = mk_hdr($urandom_range(0, 15), len, cid, seq);
    seq++;
    rsrc_q.push_back(f);
    exp_rev[cid].push_back(f);
    for (int b = 0; b < len; b++) begin
      f = W'($urandom);
      rsrc_q.push_back(f);
      exp_rev[cid].push_back(f);
    end
  endtask

  // Forward model: the link carries whole packets; each packet is the next
  // pending packet of the lane named in its header.
  task automatic model_fwd(input logic [W-1:0] flit);
    int lane;
    logic [W-1:0] e;
    fwd_log.push_back(flit);
    fwd_log_cyc.push_back(cyc);
    lane = (cur_lane < 0) ? int'(flit[1:0]) : cur_lane;
    checkOutput("fwd_pending", 64'(exp_fwd[lane].size() > 0), 64'(1));
    if (exp_fwd[lane].size() > 0) begin
      e = exp_fwd[lane].pop_front();
      checkOutput((cur_lane < 0) ? "fwd_hdr" : "fwd_body", 64'(flit), 64'(e));
      if (cur_lane < 0) begin
        remaining = int'(e[6:4]);
        if (remaining > 0) cur_lane = lane;
      end else begin
        remaining--;
        if (remaining == 0) cur_lane = -1;
      end
    end
  endtask

  task automatic model_rev(input int lane, input logic [W-1:0] flit);
    rev_log_lane.push_back(lane);
    checkOutput("rev_pending", 64'(exp_rev[lane].size() > 0), 64'(1));
    if (exp_rev[lane].size() > 0) checkOutput("rev_flit", 64'(flit), 64'(exp_rev[lane].pop_front()));
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += exp_fwd[i].size() + exp_rev[i].size();
    return s;
  endfunction

  // One clock cycle: drive inputs just after the edge, sample 1 ns later.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    cyc++;
    reset_i = rst_drv;
    for (int i = 0; i < N; i++) begin
      fwd_v_i[i]    = (src_q[i].size() > 0);
      fwd_data_i[i] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
    rev_v_i         = (rsrc_q.size() > 0);
    rev_data_i      = (rsrc_q.size() > 0) ? rsrc_q[0] : '0;
    fwd_ready_and_i = fwd_rdy_drv;
    rev_ready_and_i = rev_rdy_drv;
    #1;
    if (rst_drv) begin
      checkOutput("reset_fwd_v_o", 64'(fwd_v_o), 64'(0));
      checkOutput("reset_fwd_ready_and_o", 64'(fwd_ready_and_o), 64'(0));
      checkOutput("reset_rev_v_o", 64'(rev_v_o), 64'(0));
      checkOutput("reset_rev_ready_and_o", 64'(rev_ready_and_o), 64'(0));
      for (int i = 0; i < N; i++) begin
        src_q[i].delete();
        exp_fwd[i].delete();
        exp_rev[i].delete();
      end
      rsrc_q.delete();
      cur_lane       = -1;
      remaining      = 0;
      prev_stall     = 1'b0;
      prev_rev_stall = '0;
      return;
    end
    for (int i = 0; i < N; i++) if (fwd_v_i[i] && fwd_ready_and_o[i]) void'(src_q[i].pop_front());
    if (rev_v_i && rev_ready_and_o) void'(rsrc_q.pop_front());
    if (hold_check_en && prev_stall) begin
      checkOutput("fwd_hold_v", 64'(fwd_v_o), 64'(1));
      checkOutput("fwd_hold_data", 64'(fwd_data_o), 64'(prev_data));
    end
    prev_stall = fwd_v_o && !fwd_ready_and_i;
    prev_data  = fwd_data_o;
    if (fwd_v_o && fwd_ready_and_i) model_fwd(fwd_data_o);
    checkOutput("rev_v_onehot0", 64'($onehot0(rev_v_o)), 64'(1));
    for (int i = 0; i < N; i++) begin
      if (prev_rev_stall[i]) begin
        checkOutput("rev_hold_v", 64'(rev_v_o[i]), 64'(1));
        checkOutput("rev_hold_data", 64'(rev_data_o[i]), 64'(prev_rev_data));
      end
      prev_rev_stall[i] = rev_v_o[i] && !rev_ready_and_i[i];
      if (rev_v_o[i]) prev_rev_data = rev_data_o[i];
      if (rev_v_o[i] && rev_ready_and_i[i]) model_rev(i, rev_data_o[i]);
    end
  endtask

  task automatic clear_logs();
    fwd_log.delete();
    fwd_log_cyc.delete();
    rev_log_lane.delete();
  endtask

  initial begin
    int t0;
    int guard;
    logic saw_full;
    reset_i         = 1'b1;
    fwd_v_i         = '0;
    fwd_data_i      = '0;
    fwd_ready_and_i = 1'b0;
    rev_v_i         = 1'b0;
    rev_data_i      = '0;
    rev_ready_and_i = '0;
    rst_drv         = 1'b1;
    fwd_rdy_drv     = 1'b1;
    rev_rdy_drv     = '1;

    repeat (2) applyStimulus();
    rst_drv = 1'b0;
    applyStimulus();
    checkOutput("post_reset_fwd_ready", 64'(fwd_ready_and_o), 64'(4'hF));
    checkOutput("post_reset_rev_ready", 64'(rev_ready_and_o), 64'(1));
    checkOutput("post_reset_fwd_v", 64'(fwd_v_o), 64'(0));
    checkOutput("post_reset_rev_v", 64'(rev_v_o), 64'(0));

    // Single lane 0 packet, len=3: four flits on consecutive cycles.
    $display("[TB] single lane packet");
    clear_logs();
    add_fwd_pkt(0, 3);
    t0 = cyc + 1;
    repeat (7) applyStimulus();
    checkOutput("t1_count", 64'(fwd_log.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      if (k < fwd_log_cyc.size()) checkOutput("t1_cycle", 64'(fwd_log_cyc[k]), 64'(t0 + 1 + k));

    // rr is now 1: lane 1 beats lane 0 when both offer together.
    clear_logs();
    add_fwd_pkt(0, 0);
    add_fwd_pkt(1, 0);
    repeat (5) applyStimulus();
    checkOutput("t1_rr_count", 64'(fwd_log.size()), 64'(2));
    if (fwd_log.size() == 2) begin
      checkOutput("t1_rr_first", 64'(fwd_log[0][1:0]), 64'(1));
      checkOutput("t1_rr_second", 64'(fwd_log[1][1:0]), 64'(0));
    end

    // Reset returns rr to 0; two len=2 packets go out whole and back-to-back.
    $display("[TB] competing lanes");
    rst_drv = 1'b1;
    applyStimulus();
    rst_drv = 1'b0;
    clear_logs();
    add_fwd_pkt(0, 2);
    add_fwd_pkt(1, 2);
    t0 = cyc + 1;
    repeat (10) applyStimulus();
    checkOutput("t2_count", 64'(fwd_log.size()), 64'(6));
    for (int k = 0; k < 6; k++)
      if (k < fwd_log_cyc.size()) checkOutput("t2_cycle", 64'(fwd_log_cyc[k]), 64'(t0 + 1 + k));
    if (fwd_log.size() == 6) begin
      checkOutput("t2_first_lane", 64'(fwd_log[0][1:0]), 64'(0));
      checkOutput("t2_second_lane", 64'(fwd_log[3][1:0]), 64'(1));
    end

    // Toggling downstream ready: held flits stay stable and lane 1 fills.
    $display("[TB] stalled link");
    clear_logs();
    hold_check_en = 1'b1;
    saw_full      = 1'b0;
    add_fwd_pkt(1, 2);
    for (int k = 0; k < 12; k++) begin
      fwd_rdy_drv = (k % 2 == 0);
      applyStimulus();
      if (!fwd_ready_and_o[1]) saw_full = 1'b1;
    end
    fwd_rdy_drv   = 1'b1;
    hold_check_en = 1'b0;
    checkOutput("t3_lane1_full", 64'(saw_full), 64'(1));
    checkOutput("t3_count", 64'(fwd_log.size()), 64'(3));

    // Reverse packet for lane 1 waits until lane 1 is ready.
    $display("[TB] reverse demux");
    clear_logs();
    rev_rdy_drv = 4'b0001;
    add_rev_pkt(1, 1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      checkOutput("t4_rev_v0_low", 64'(rev_v_o[0]), 64'(0));
    end
    checkOutput("t4_no_xfer", 64'(rev_log_lane.size()), 64'(0));
    checkOutput("t4_lane1_waiting", 64'(rev_v_o[1]), 64'(1));
    rev_rdy_drv = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("t4_rev_v0_low", 64'(rev_v_o[0]), 64'(0));
    end
    checkOutput("t4_count", 64'(rev_log_lane.size()), 64'(2));
    for (int k = 0; k < rev_log_lane.size(); k++) checkOutput("t4_lane", 64'(rev_log_lane[k]), 64'(1));
    rev_rdy_drv = '1;

    // Reset after the 2nd of 5 flits; rr must restart at 0.
    $display("[TB] mid-packet reset");
    clear_logs();
    add_fwd_pkt(0, 4);
    guard = 0;
    while (fwd_log.size() < 2 && guard < 20) begin
      applyStimulus();
      guard++;
    end
    checkOutput("t5_two_flits", 64'(fwd_log.size()), 64'(2));
    rst_drv = 1'b1;
    applyStimulus();
    rst_drv = 1'b0;
    applyStimulus();
    checkOutput("t5_after_fwd_ready", 64'(fwd_ready_and_o), 64'(4'hF));
    checkOutput("t5_after_fwd_v", 64'(fwd_v_o), 64'(0));
    checkOutput("t5_after_rev_ready", 64'(rev_ready_and_o), 64'(1));
    clear_logs();
    add_fwd_pkt(3, 0);
    add_fwd_pkt(1, 0);
    repeat (5) applyStimulus();
    checkOutput("t5_count", 64'(fwd_log.size()), 64'(2));
    if (fwd_log.size() == 2) begin
      checkOutput("t5_first_lane", 64'(fwd_log[0][1:0]), 64'(1));
      checkOutput("t5_second_lane", 64'(fwd_log[1][1:0]), 64'(3));
    end

    // len=0 packets on every lane: grants 0,1,2,3,0 one per cycle.
    $display("[TB] round-robin len=0");
    clear_logs();
    add_fwd_pkt(0, 0);
    add_fwd_pkt(1, 0);
    add_fwd_pkt(2, 0);
    add_fwd_pkt(3, 0);
    add_fwd_pkt(0, 0);
    t0 = cyc + 1;
    repeat (8) applyStimulus();
    checkOutput("t6_count", 64'(fwd_log.size()), 64'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < fwd_log.size()) begin
        checkOutput("t6_lane", 64'(fwd_log[k][1:0]), 64'(k % 4));
        checkOutput("t6_cycle", 64'(fwd_log_cyc[k]), 64'(t0 + 1 + k));
      end
    end

    // Random traffic in both directions against the packet model.
    $display("[TB] random traffic");
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        int lane;
        lane = $urandom_range(0, N - 1);
        if (src_q[lane].size() < 20) add_fwd_pkt(lane, $urandom_range(0, 7));
      end
      if ($urandom_range(0, 2) == 0 && rsrc_q.size() < 20) add_rev_pkt($urandom_range(0, N - 1), $urandom_range(0, 7));
      fwd_rdy_drv = ($urandom_range(0, 3) != 0);
      rev_rdy_drv = N'($urandom);
      applyStimulus();
    end
    fwd_rdy_drv = 1'b1;
    rev_rdy_drv = '1;
    guard = 0;
    while (pending() > 0 && guard < 2000) begin
      applyStimulus();
      guard++;
    end
    checkOutput("drain_all_delivered", 64'(pending()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
